// File: rtl/lcd_pixel_pacer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared types and screen geometry for the LCD pixel pacer slice.
//            Provides RGB888 pixel and FIFO entry types plus the pacer state
//            encoding used by lcd_pixel_pacer and lcd_pixel_fifo.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int FRAME_PIX = SCREEN_W * SCREEN_H;
    // Output pixel counter width; 17 bits for the default 320x240 frame.
    localparam int OUT_CNT_W = $clog2(FRAME_PIX);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef struct packed {
        logic    sof;
        rgb888_t rgb;
    } pix_entry_t;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        WAIT_SOF  = 2'd1,
        STREAM    = 2'd2
    } pacer_state_e;

endpackage

`default_nettype wire

// File: rtl/lcd_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pixel_fifo
// Purpose  : Synchronous first-word-fall-through FIFO of pix_entry_t.
//            The head entry is visible on o_head whenever o_empty is low.
//            i_flush empties the FIFO and overrides a same-cycle push/pop.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            i_flush        - discard all entries
//            i_push, i_data - write request and entry (ignored when full)
//            i_pop          - consume head (ignored when empty)
//            o_head         - current head entry
//            o_full/o_empty - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module lcd_pixel_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic       i_push,
    input  pix_entry_t i_data,
    input  logic       i_pop,
    output pix_entry_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int c_addr_w = $clog2(DEPTH);

    pix_entry_t          r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [c_addr_w:0]   r_wr_ptr;
    logic [c_addr_w:0]   r_rd_ptr;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]) &&
                       (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[c_addr_w-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/lcd_pixel_pacer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pixel_pacer
// Purpose  : Buffers the PPU RGB888 stream and issues lcd_write strobes to the
//            ILI9341 byte driver no closer than PIX_PERIOD clocks apart, while
//            keeping the stream aligned to the driver's free-running x/y.
// Ports    : clk, rst             - 16 MHz clock, synchronous active-high reset
//            in_valid/in_ready    - pixel handshake
//            in_sof, in_r/g/b     - first-pixel-of-frame flag and colour
//            lcd_init             - driver initialized; low forces re-sync
//            lcd_write            - one-cycle pixel strobe
//            lcd_col_r/g/b        - pixel colour, held between strobes
//            ovf_err, frame_err   - sticky error flags
//            tpat_en              - test pattern enable (macro builds only)
// Options  : LCD_PACER_TESTPAT_EN - adds tpat_en and the colour bar generator
// Revision : 1.0 - initial release
// ============================================================================
module lcd_pixel_pacer #(
    parameter int FIFO_DEPTH = 16,
    parameter int PIX_PERIOD = 4,
    parameter int SCREEN_W   = lcd_pkg::SCREEN_W,
    parameter int SCREEN_H   = lcd_pkg::SCREEN_H
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    output logic       in_ready,
    input  logic       lcd_init,
`ifdef LCD_PACER_TESTPAT_EN
    input  logic       tpat_en,
`endif
    output logic       lcd_write,
    output logic [7:0] lcd_col_r,
    output logic [7:0] lcd_col_g,
    output logic [7:0] lcd_col_b,
    output logic       ovf_err,
    output logic       frame_err
);
    import lcd_pkg::*;

    localparam int                   c_phase_w      = (PIX_PERIOD > 1) ? $clog2(PIX_PERIOD) : 1;
    localparam logic [c_phase_w-1:0] c_phase_reload = c_phase_w'(PIX_PERIOD - 1);
    localparam logic [OUT_CNT_W-1:0] c_frame_last   = OUT_CNT_W'(SCREEN_W * SCREEN_H - 1);

    pacer_state_e          r_state;
    logic [c_phase_w-1:0]  r_phase;
    logic [OUT_CNT_W-1:0]  r_out_cnt;
    logic                  r_write;
    rgb888_t               r_col;
    logic                  r_ovf;
    logic                  r_frame_err;

    pix_entry_t            w_push_data;
    pix_entry_t            w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_stream;
    logic                  w_tpat;
    logic                  w_slot;
    logic                  w_wr_evt;
    logic                  w_sof_late;
    logic [OUT_CNT_W-1:0]  w_cnt_next;
    rgb888_t               w_tpat_col;

    assign w_stream   = (r_state == STREAM);
    assign w_slot     = w_stream && lcd_init && (r_phase == '0);
    assign w_wr_evt   = w_slot && (w_tpat || !w_empty);
    // A sof entry arriving mid-frame stays at the head while black pixels pad
    // the frame out; it is only consumed once out_cnt is back at zero.
    assign w_sof_late = w_head.sof && (r_out_cnt != '0);
    assign w_pop      = w_wr_evt && !w_tpat && !w_sof_late;
    assign w_cnt_next = (r_out_cnt == c_frame_last) ? '0 : r_out_cnt + OUT_CNT_W'(1);

    assign in_ready    = !rst && (!w_stream || w_tpat || !w_full);
    assign w_push      = in_valid && in_ready && lcd_init &&
                         (((r_state == WAIT_SOF) && in_sof) || (w_stream && !w_tpat));
    // The test pattern drains the FIFO by holding it flushed.
    assign w_flush     = (r_state == WAIT_INIT) || !lcd_init || w_tpat;
    assign w_push_data = {in_sof, in_r, in_g, in_b};

    lcd_pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef LCD_PACER_TESTPAT_EN
    // Bar position tracked incrementally so no divider is needed; it follows
    // out_cnt % SCREEN_W because the frame is a whole number of lines.
    localparam int c_bar_w = SCREEN_W / 8;
    localparam int c_x_w   = $clog2(SCREEN_W);
    localparam int c_bpx_w = (c_bar_w > 1) ? $clog2(c_bar_w) : 1;

    logic [c_x_w-1:0]   r_x;
    logic [c_bpx_w-1:0] r_bar_px;
    logic [2:0]         r_bar;

    assign w_tpat     = w_stream && tpat_en;
    // Bar order W,Y,C,G,M,R,B,K maps to r=~bar[1], g=~bar[2], b=~bar[0].
    assign w_tpat_col = {{8{~r_bar[1]}}, {8{~r_bar[2]}}, {8{~r_bar[0]}}};

    always_ff @(posedge clk) begin
        if (rst || !lcd_init) begin
            r_x      <= '0;
            r_bar_px <= '0;
            r_bar    <= '0;
        end else if (w_wr_evt) begin
            if (r_x == c_x_w'(SCREEN_W - 1)) begin
                r_x      <= '0;
                r_bar_px <= '0;
                r_bar    <= '0;
            end else begin
                r_x <= r_x + 1'b1;
                if (r_bar_px == c_bpx_w'(c_bar_w - 1)) begin
                    r_bar_px <= '0;
                    r_bar    <= r_bar + 1'b1;
                end else begin
                    r_bar_px <= r_bar_px + 1'b1;
                end
            end
        end
    end
`else
    assign w_tpat     = 1'b0;
    assign w_tpat_col = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= WAIT_INIT;
            r_phase     <= '0;
            r_out_cnt   <= '0;
            r_write     <= 1'b0;
            r_col       <= '0;
            r_ovf       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_write <= 1'b0;
            if (w_stream && in_valid && !in_ready) r_ovf <= 1'b1;

            if (!lcd_init) begin
                // Driver lost or re-initialising: restart alignment from scratch.
                r_state   <= WAIT_INIT;
                r_phase   <= '0;
                r_out_cnt <= '0;
            end else begin
                case (r_state)
                    WAIT_INIT: r_state <= WAIT_SOF;
                    WAIT_SOF:  if (in_valid && in_sof) r_state <= STREAM;
                    STREAM: begin
                        if (w_wr_evt) begin
                            r_write   <= 1'b1;
                            r_phase   <= c_phase_reload;
                            r_out_cnt <= w_cnt_next;
                            if (w_tpat) begin
                                r_col <= w_tpat_col;
                            end else if (w_sof_late) begin
                                r_col       <= '0;
                                r_frame_err <= 1'b1;
                            end else begin
                                r_col <= w_head.rgb;
                                if (!w_head.sof && (r_out_cnt == '0)) r_frame_err <= 1'b1;
                            end
                        end else if (r_phase != '0) begin
                            r_phase <= r_phase - 1'b1;
                        end
                    end
                    default: r_state <= WAIT_INIT;
                endcase
            end
        end
    end

    assign lcd_write = r_write;
    assign lcd_col_r = r_col.r;
    assign lcd_col_g = r_col.g;
    assign lcd_col_b = r_col.b;
    assign ovf_err   = r_ovf;
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire
